branch_redirect_controller: RTL and testbench
=============================================

# branch_redirect_controller

Sequences front-end recovery after a branch/jump resolves in execute or a trap is raised. Accepts one branch resolution per cycle from the branch evaluator (mispredict flag plus resolved next-instruction address) and one trap request, arbitrates them (trap wins), then drives a timed pipeline flush followed by a held PC redirect handshake with fetch. Sits between the execute-stage branch evaluator and the fetch/PC logic, and also keeps branch and mispredict statistics counters.

## Interface
- XLEN, 32, address width
- FLUSH_CYCLES, 2, cycles `flush` is held per recovery (legal range ≥1)
- CNT_WIDTH, 32, width of statistics counters

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- resolve_valid  input  1  a branch/jump resolution is presented this cycle
- branch_mispredicted  input  1  the presented resolution was mispredicted (qualified by resolve_valid)
- next_instruction  input  XLEN  correct next PC for the presented resolution
- resolve_ready  output  1  controller accepts resolutions this cycle
- trap_valid  input  1  trap redirect request, single-cycle pulse, always accepted
- trap_target  input  XLEN  trap handler address
- fetch_ready  input  1  fetch consumes `redirect_pc` this cycle
- flush  output  1  kill all younger in-flight instructions
- redirect_valid  output  1  `redirect_pc` must be loaded into the PC
- redirect_pc  output  XLEN  recovery target
- branch_count  output  CNT_WIDTH  accepted resolutions
- mispredict_count  output  CNT_WIDTH  accepted mispredicted resolutions

## Operation
- States: IDLE, FLUSH, REDIRECT. Reset → IDLE; flush=0, redirect_valid=0, redirect_pc=0, counters=0, internal flush counter=0.
- resolve_ready = (state==IDLE) && !trap_valid (combinational). All other outputs are registered.
- Accept = resolve_valid && resolve_ready. Resolutions presented when not ready are dropped and not counted (they are wrong-path by construction).
- IDLE:
  - trap_valid → latch trap_target, load flush counter with FLUSH_CYCLES, → FLUSH. A simultaneous resolution is dropped.
  - else accept with branch_mispredicted=1 → latch next_instruction, branch_count+1, mispredict_count+1, → FLUSH.
  - else accept with branch_mispredicted=0 → branch_count+1, stay IDLE.
- FLUSH: flush=1; counter decrements each cycle; after FLUSH_CYCLES cycles → REDIRECT.
- REDIRECT: flush=0, redirect_valid=1, redirect_pc stable; on a cycle with fetch_ready=1 → IDLE (redirect_valid drops the next cycle).
- Trap in FLUSH or REDIRECT: replaces the latched target with trap_target, reloads the flush counter, → FLUSH (redirect_valid deasserts). Trap during trap: last wins.
- Counters wrap modulo 2^CNT_WIDTH and never saturate.
- Reset asserted mid-recovery: immediately IDLE, all outputs 0; no pending redirect survives.

## Timing
- Mispredict accepted in cycle N: flush=1 in cycles N+1 … N+FLUSH_CYCLES; redirect_valid=1 from N+FLUSH_CYCLES+1 until the cycle fetch_ready is sampled high (inclusive); resolve_ready=1 the following cycle.
- With fetch_ready tied high, accept-to-next-accept is FLUSH_CYCLES+2 cycles.
- Counter updates are visible the cycle after acceptance.
- redirect_pc must not change while redirect_valid=1, except when a trap preempts it (redirect_valid drops first).

## Test plan
- Reset, then correct-predicted resolves in 5 consecutive cycles → branch_count=5, mispredict_count=0, flush never asserted, resolve_ready constantly 1.
- Mispredict with next_instruction=0x0000_1040 at cycle 10, FLUSH_CYCLES=2, fetch_ready=1 → flush in cycles 11-12; redirect_valid=1 with redirect_pc=0x1040 in cycle 13; resolve_ready=1 in cycle 14; mispredict_count=1.
- Same as above but fetch_ready=0 for cycles 13-16 → redirect_valid and redirect_pc=0x1040 held through cycle 17 (fetch_ready=1); resolves presented during 11-17 are not counted.
- trap_valid (target 0x0000_0200) and a mispredict in the same IDLE cycle → redirect_pc=0x200, branch_count unchanged; trap during REDIRECT of a branch to 0x1040 → flush restarts for 2 cycles, then redirect_pc=0x200.
- CNT_WIDTH=4: 17 accepted mispredicts → mispredict_count=1 (wrap).
- Assert reset during FLUSH → flush, redirect_valid and counters are 0 immediately (asynchronous); state is IDLE after release.

Source files
------------

// File: rtl/branch_redirect_controller.sv
// Front-end recovery sequencer: arbitrates branch resolutions against trap
// requests (trap wins), runs a timed pipeline flush, then holds a PC redirect
// until fetch consumes it. Also keeps branch and mispredict statistics.
module branch_redirect_controller #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    // Branch evaluator side
    input  logic                 resolve_valid,
    input  logic                 branch_mispredicted,
    input  logic [XLEN-1:0]      next_instruction,
    output logic                 resolve_ready,
    // Trap request, single-cycle pulse
    input  logic                 trap_valid,
    input  logic [XLEN-1:0]      trap_target,
    // Fetch / PC side
    input  logic                 fetch_ready,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    // Statistics
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    // Wide enough to hold FLUSH_CYCLES itself.
    localparam int unsigned FcWidth = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRedirect
    } state_e;

    state_e             state_q;
    logic [FcWidth-1:0] flush_cnt_q;
    logic               accept;
    logic               accept_mispredict;

    // Resolutions are only taken while idle and no trap competes for the slot.
    // Anything presented otherwise is wrong-path and silently dropped.
    assign resolve_ready     = (state_q == StIdle) && !trap_valid;
    assign accept            = resolve_valid && resolve_ready;
    assign accept_mispredict = accept && branch_mispredicted;

    // Recovery FSM with registered flush / redirect outputs and latched target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            flush_cnt_q    <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (trap_valid) begin
            // A trap preempts any state, including an in-progress recovery:
            // retarget and restart the full flush window.
            state_q        <= StFlush;
            flush_cnt_q    <= FcWidth'(FLUSH_CYCLES);
            flush          <= 1'b1;
            redirect_valid <= 1'b0;
            redirect_pc    <= trap_target;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept_mispredict) begin
                        state_q     <= StFlush;
                        flush_cnt_q <= FcWidth'(FLUSH_CYCLES);
                        flush       <= 1'b1;
                        redirect_pc <= next_instruction;
                    end
                end
                StFlush: begin
                    flush_cnt_q <= flush_cnt_q - FcWidth'(1);
                    // Last flush cycle: hand over to the redirect handshake.
                    if (flush_cnt_q == FcWidth'(1)) begin
                        state_q        <= StRedirect;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b1;
                    end
                end
                StRedirect: begin
                    if (fetch_ready) begin
                        state_q        <= StIdle;
                        redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    // Statistics counters; wrap naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (accept) begin
                branch_count <= branch_count + CNT_WIDTH'(1);
            end
            if (accept_mispredict) begin
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Self-checking bench for branch_redirect_controller: directed scenarios with
// literal expectations plus randomized traffic against a timeline model.
module tb_branch_redirect_controller;

    localparam int XLEN = 32;
    localparam int FC   = 2;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            resolve_valid = 1'b0;
    logic            branch_mispredicted = 1'b0;
    logic [XLEN-1:0] next_instruction = '0;
    logic            resolve_ready;
    logic            trap_valid = 1'b0;
    logic [XLEN-1:0] trap_target = '0;
    logic            fetch_ready = 1'b1;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   branch_count;
    logic [CW-1:0]   mispredict_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_redirect_controller #(
        .XLEN        (XLEN),
        .FLUSH_CYCLES(FC),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .resolve_valid      (resolve_valid),
        .branch_mispredicted(branch_mispredicted),
        .next_instruction   (next_instruction),
        .resolve_ready      (resolve_ready),
        .trap_valid         (trap_valid),
        .trap_target        (trap_target),
        .fetch_ready        (fetch_ready),
        .flush              (flush),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .branch_count       (branch_count),
        .mispredict_count   (mispredict_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: a recovery started by an event in cycle t0 flushes in
    // cycles t0+1..t0+FC and redirects from t0+FC+1 until fetch takes it.
    bit          m_active;
    int          m_t0;
    logic [31:0] m_pc;
    int          m_bc;
    int          m_mc;
    int          cyc;

    function automatic bit m_in_flush();
        return m_active && (cyc - m_t0) >= 1 && (cyc - m_t0) <= FC;
    endfunction

    function automatic bit m_in_redir();
        return m_active && (cyc - m_t0) > FC;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_t0     = 0;
            m_pc     = '0;
            m_bc     = 0;
            m_mc     = 0;
            cyc      = 0;
        end else begin
            if (trap_valid) begin
                m_active = 1'b1;
                m_t0     = cyc;
                m_pc     = trap_target;
            end else if (!m_active) begin
                if (resolve_valid) begin
                    m_bc = (m_bc + 1) % (1 << CW);
                    if (branch_mispredicted) begin
                        m_mc     = (m_mc + 1) % (1 << CW);
                        m_active = 1'b1;
                        m_t0     = cyc;
                        m_pc     = next_instruction;
                    end
                end
            end else if (m_in_redir() && fetch_ready) begin
                m_active = 1'b0;
            end
            cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("flush", flush, m_in_flush());
            chk("redirect_valid", redirect_valid, m_in_redir());
            if (m_in_redir()) chk("redirect_pc", redirect_pc, m_pc);
            chk("resolve_ready", resolve_ready, !m_active && !trap_valid);
            chk("branch_count", branch_count, m_bc);
            chk("mispredict_count", mispredict_count, m_mc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        resolve_valid       = 1'b0;
        branch_mispredicted = 1'b0;
        trap_valid          = 1'b0;
        fetch_ready         = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        quiet();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset flush", flush, 0);
        chk("reset redirect_valid", redirect_valid, 0);
        chk("reset redirect_pc", redirect_pc, 0);
        chk("reset branch_count", branch_count, 0);
        chk("reset mispredict_count", mispredict_count, 0);
        chk("reset resolve_ready", resolve_ready, 1);

        // Five correctly predicted resolves back to back.
        for (int i = 0; i < 5; i++) begin
            resolve_valid       = 1'b1;
            branch_mispredicted = 1'b0;
            next_instruction    = $urandom;
            tick();
        end
        quiet();
        chk("5 resolves branch_count", branch_count, 5);
        chk("5 resolves mispredict_count", mispredict_count, 0);

        // Mispredict to 0x1040 with fetch always ready.
        resolve_valid = 1'b1; branch_mispredicted = 1'b1; next_instruction = 32'h1040;
        tick();
        quiet();
        chk("mp N+1 flush", flush, 1);
        chk("mp branch_count", branch_count, 6);
        chk("mp mispredict_count", mispredict_count, 1);
        tick();
        chk("mp N+2 flush", flush, 1);
        tick();
        chk("mp N+3 flush", flush, 0);
        chk("mp N+3 redirect_valid", redirect_valid, 1);
        chk("mp N+3 redirect_pc", redirect_pc, 32'h1040);
        tick();
        chk("mp N+4 resolve_ready", resolve_ready, 1);
        chk("mp N+4 redirect_valid", redirect_valid, 0);

        // Mispredict with fetch stalled; wrong-path resolves must be dropped.
        resolve_valid = 1'b1; branch_mispredicted = 1'b1; next_instruction = 32'h1040;
        fetch_ready = 1'b0;
        tick();
        branch_mispredicted = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) fetch_ready = 1'b1;
            chk("hold redirect_valid", redirect_valid, 1);
            chk("hold redirect_pc", redirect_pc, 32'h1040);
            tick();
        end
        quiet();
        chk("hold released redirect_valid", redirect_valid, 0);
        chk("hold branch_count", branch_count, 7);
        chk("hold mispredict_count", mispredict_count, 2);

        // Trap and mispredict in the same idle cycle: trap wins.
        trap_valid = 1'b1; trap_target = 32'h200;
        resolve_valid = 1'b1; branch_mispredicted = 1'b1; next_instruction = 32'h1040;
        tick();
        quiet();
        chk("trap+mp flush", flush, 1);
        chk("trap+mp branch_count", branch_count, 7);
        tick();
        tick();
        chk("trap+mp redirect_valid", redirect_valid, 1);
        chk("trap+mp redirect_pc", redirect_pc, 32'h200);
        tick();

        // Trap arriving during REDIRECT restarts the flush.
        resolve_valid = 1'b1; branch_mispredicted = 1'b1; next_instruction = 32'h1040;
        fetch_ready = 1'b0;
        tick();
        resolve_valid = 1'b0; branch_mispredicted = 1'b0;
        tick();
        tick();
        chk("preempt redirect_pc before", redirect_pc, 32'h1040);
        trap_valid = 1'b1; trap_target = 32'h200;
        tick();
        trap_valid = 1'b0;
        chk("preempt flush 1", flush, 1);
        chk("preempt redirect_valid drop", redirect_valid, 0);
        tick();
        chk("preempt flush 2", flush, 1);
        tick();
        chk("preempt redirect_valid", redirect_valid, 1);
        chk("preempt redirect_pc", redirect_pc, 32'h200);
        fetch_ready = 1'b1;
        tick();
        chk("preempt branch_count", branch_count, 8);
        chk("preempt mispredict_count", mispredict_count, 3);

        // Asynchronous reset in the middle of a flush.
        resolve_valid = 1'b1; branch_mispredicted = 1'b1; next_instruction = 32'h3000;
        tick();
        quiet();
        chk("pre-reset flush", flush, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset flush", flush, 0);
        chk("async reset redirect_valid", redirect_valid, 0);
        chk("async reset branch_count", branch_count, 0);
        chk("async reset mispredict_count", mispredict_count, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post-reset resolve_ready", resolve_ready, 1);
        chk("post-reset flush", flush, 0);

        // 17 mispredicts from zero wrap a 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            resolve_valid = 1'b1; branch_mispredicted = 1'b1; next_instruction = $urandom;
            tick();
            quiet();
            repeat (3) tick();
        end
        chk("wrap mispredict_count", mispredict_count, 1);
        chk("wrap branch_count", branch_count, 1);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            trap_valid          = ($urandom_range(0, 15) == 0);
            trap_target         = $urandom;
            resolve_valid       = $urandom_range(0, 1) == 1;
            branch_mispredicted = ($urandom_range(0, 2) == 0);
            next_instruction    = $urandom;
            fetch_ready         = ($urandom_range(0, 3) != 0);
            tick();
        end
        quiet();
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
